// File: rtl/sub_iterative_64_if.sv
// sub_iterative_64_if
//   Request/response bundle for the iterative subtractor.
//   start  : operation request (from master)
//   a, b   : minuend / subtrahend, captured with an accepted start
//   busy   : subtraction in progress
//   done   : one-cycle pulse when diff/borrow update
//   diff   : a - b modulo 2^WIDTH, held until the next done
//   borrow : 1 when a < b (unsigned), held with diff
interface sub_iterative_64_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow
  );
endinterface

// File: rtl/sub_iterative_64.sv
// sub_iterative_64
//   Multi-cycle unsigned subtractor: diff = a - b, one CHUNK-bit slice per clock.
//   The inter-slice carry lives only in carry_q, so the longest combinational
//   carry chain is CHUNK bits.
//   Ports:
//     clk    : clock, all state on rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : sub_iterative_64_if.slave (start/a/b in, busy/done/diff/borrow out)
//   WIDTH must be a multiple of CHUNK, with at least two chunks.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | waiting for start
//   RUN   | one slice of a + ~b + carry per edge, NCHUNK edges in total
//   FIN   | all slices ready; results publish on the next edge, start accepted
module sub_iterative_64 #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  sub_iterative_64_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] shadow_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  logic             accept;
  logic             last_chunk;
  logic [CHUNK:0]   slice_sum;

  // start is honoured in FIN as well, giving back-to-back operation
  assign accept     = bus.start && ((state_q == IDLE) || (state_q == FIN));
  assign last_chunk = (cnt_q == CW'(NCHUNK - 1));

  // Operands shift right each RUN cycle, so the active slice is always the low chunk
  assign slice_sum = {1'b0, a_q[CHUNK-1:0]}
                   + {1'b0, ~b_q[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = RUN;
      end
      RUN: begin
        if (last_chunk) state_d = FIN;
      end
      FIN: begin
        state_d = accept ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      shadow_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else if (accept) begin
      a_q     <= bus.a;
      b_q     <= bus.b;
      carry_q <= 1'b1;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_q      <= a_q >> CHUNK;
      b_q      <= b_q >> CHUNK;
      // New slice enters at the top; after NCHUNK shifts slice 0 sits at the bottom
      shadow_q <= {slice_sum[CHUNK-1:0], shadow_q[WIDTH-1:CHUNK]};
      carry_q  <= slice_sum[CHUNK];
      cnt_q    <= cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      busy_q <= (state_d == RUN);
      done_q <= (state_q == FIN);
      if (state_q == FIN) begin
        diff_q   <= shadow_q;
        // Final carry out of a + ~b + 1 is the inverse of the borrow
        borrow_q <= ~carry_q;
      end
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;

endmodule

// File: tb/tb_sub_iterative_64.sv
// tb_sub_iterative_64
//   Randomized and directed stimulus for sub_iterative_64. A transaction-level
//   model (operation in flight + cycles remaining) predicts busy/done/diff/borrow
//   every cycle; directed cases also pin literal results and timing.
module tb_sub_iterative_64;

  localparam int NCHUNK = 4;

  logic clk;
  logic rst_n;

  sub_iterative_64_if #(.WIDTH(64)) bus ();

  sub_iterative_64 #(.WIDTH(64), .CHUNK(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          rem;
  logic [63:0] cur_a, cur_b;
  logic [63:0] e_diff;
  logic        e_done, e_busy, e_borrow;

  always @(posedge clk or negedge rst_n) begin
    int pre;
    if (!rst_n) begin
      rem = 0; e_done = 0; e_busy = 0; e_diff = '0; e_borrow = 0;
      cur_a = '0; cur_b = '0;
    end else begin
      pre    = rem;
      e_done = 0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          e_done   = 1;
          e_diff   = cur_a - cur_b;
          e_borrow = (cur_a < cur_b);
        end
      end
      // Accepted when idle or in the final (publishing) cycle of an op
      if (bus.start === 1'b1 && (pre == 0 || pre == 1)) begin
        cur_a = bus.a;
        cur_b = bus.b;
        rem   = NCHUNK + 1;
      end
      e_busy = (rem >= 2);
    end
  end

  always @(negedge clk) begin
    chk("busy",   {63'd0, bus.busy},   {63'd0, e_busy});
    chk("done",   {63'd0, bus.done},   {63'd0, e_done});
    chk("diff",   bus.diff,            e_diff);
    chk("borrow", {63'd0, bus.borrow}, {63'd0, e_borrow});
  end

  // ---------------- stimulus ----------------
  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] d, output logic br, output int nbusy);
    bit got;
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = {$urandom, $urandom};
    bus.b = {$urandom, $urandom};
    nbusy = bus.busy ? 1 : 0;
    got = 0; d = '0; br = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.busy) nbusy++;
      if (bus.done) begin
        got = 1; d = bus.diff; br = bus.borrow;
      end
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL done_timeout: got no done expected done within 20 cycles");
    end
  endtask

  initial begin
    logic [63:0] d;
    logic        br;
    int          nb, ndone, gap;
    logic [63:0] dsave;

    rst_n = 1'b0; bus.start = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    chk("reset_diff", bus.diff, 64'd0);
    chk("reset_busy", {63'd0, bus.busy}, 64'd0);
    rst_n = 1'b1;

    // 1: basic
    run_op(64'd5, 64'd3, d, br, nb);
    chk("t1_diff", d, 64'd2);
    chk("t1_borrow", {63'd0, br}, 64'd0);
    chk("t1_busy_cycles", 64'(nb), 64'd4);

    // 2: negative result and equal operands
    run_op(64'd3, 64'd5, d, br, nb);
    chk("t2_diff", d, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("t2_borrow", {63'd0, br}, 64'd1);
    run_op(64'hDEAD_BEEF, 64'hDEAD_BEEF, d, br, nb);
    chk("t2_eq_diff", d, 64'd0);
    chk("t2_eq_borrow", {63'd0, br}, 64'd0);

    // 3: borrow rippling across chunk boundaries
    run_op(64'h0001_0000_0000_0000, 64'd1, d, br, nb);
    chk("t3_diff", d, 64'h0000_FFFF_FFFF_FFFF);
    chk("t3_borrow", {63'd0, br}, 64'd0);
    run_op(64'd0, 64'd1, d, br, nb);
    chk("t3_ones_diff", d, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t3_ones_borrow", {63'd0, br}, 64'd1);

    // 4: start while busy is ignored
    @(negedge clk); bus.start = 1'b1; bus.a = 64'd7; bus.b = 64'd2;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); bus.start = 1'b1; bus.a = 64'd9; bus.b = 64'd9;
    @(negedge clk); bus.start = 1'b0;
    ndone = 0; dsave = '0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done) begin ndone++; dsave = bus.diff; end
    end
    chk("t4_done_count", 64'(ndone), 64'd1);
    chk("t4_diff", dsave, 64'd5);

    // 5: back-to-back via start in FIN
    @(negedge clk); bus.start = 1'b1; bus.a = 64'd100; bus.b = 64'd58;
    @(negedge clk); bus.start = 1'b0;
    gap = 0;
    for (int i = 0; i < 10 && gap == 0; i++) begin
      @(negedge clk);
      if (!bus.busy) gap = 1;
    end
    chk("t5_reached_fin", 64'(gap), 64'd1);
    bus.start = 1'b1; bus.a = 64'd20; bus.b = 64'd1;
    @(negedge clk); bus.start = 1'b0;
    chk("t5_first_done", {63'd0, bus.done}, 64'd1);
    chk("t5_first_diff", bus.diff, 64'd42);
    chk("t5_no_idle", {63'd0, bus.busy}, 64'd1);
    gap = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      gap++;
      if (bus.done) break;
    end
    chk("t5_gap", 64'(gap), 64'd5);
    chk("t5_second_diff", bus.diff, 64'd19);

    // 6: async reset in the second RUN cycle
    run_op(64'd50, 64'd8, d, br, nb);
    chk("t6_pre_diff", d, 64'd42);
    @(negedge clk); bus.start = 1'b1; bus.a = 64'd1; bus.b = 64'd2;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy",   {63'd0, bus.busy},   64'd0);
    chk("t6_rst_done",   {63'd0, bus.done},   64'd0);
    chk("t6_rst_diff",   bus.diff,            64'd0);
    chk("t6_rst_borrow", {63'd0, bus.borrow}, 64'd0);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("t6_no_done", 64'(ndone), 64'd0);
    run_op(64'd32, 64'd32, d, br, nb);
    chk("t6_after_diff", d, 64'd0);
    chk("t6_after_borrow", {63'd0, br}, 64'd0);

    // Sweep of small operands, checked by the model every cycle
    for (int x = 0; x <= 32; x++)
      for (int y = 0; y <= 32; y++)
        run_op(64'(x), 64'(y), d, br, nb);

    // Random full-width pairs
    for (int i = 0; i < 200; i++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = (i % 10 == 0) ? ra : {$urandom, $urandom};
      run_op(ra, rb, d, br, nb);
    end

    // Random start pressure, including starts while busy and in FIN
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 2) == 0);
      bus.a = {$urandom, $urandom};
      bus.b = {$urandom, $urandom};
    end
    @(negedge clk); bus.start = 1'b0;
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
